// File: rtl/boot_img_loader.sv
// Boot image loader: copies a ROM image into exec SRAM over TL-UL, checksums it,
// and enables core fetch only after a clean copy whose checksum matches.
package tlul_pkg;
    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [13:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

// Folds the command fields (address, opcode, mask) into a 7-bit integrity code.
module tlul_cmd_intg_gen
    import tlul_pkg::*;
(
    input  tl_h2d_t i_tl,
    output tl_h2d_t o_tl
);
    logic [38:0] w_payload;
    logic [6:0]  w_cmd_intg;

    assign w_payload = {i_tl.a_address, i_tl.a_opcode, i_tl.a_mask};

    always_comb begin
        w_cmd_intg = '0;
        for (int i = 0; i < 39; i++) begin
            w_cmd_intg[i % 7] = w_cmd_intg[i % 7] ^ w_payload[i];
        end
    end

    always_comb begin
        o_tl                 = i_tl;
        o_tl.a_user.cmd_intg = w_cmd_intg;
    end
endmodule

// state    | meaning
// IDLE     | out of reset, waiting for start
// RD_REQ   | Get to src presented on A channel
// RD_RSP   | waiting for read data
// WR_REQ   | PutFullData of captured word to dst presented
// WR_RSP   | waiting for write ack
// CHECK    | compare running checksum with expected
// DONE     | copy clean and checksum matched, fetch enabled
// ERROR    | bus error, misalignment or checksum mismatch
module boot_img_loader
    import tlul_pkg::*;
#(
    parameter int unsigned LenW        = 16,
    parameter bit          SrcAlignChk = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [31:0]     src_addr_i,
    input  logic [31:0]     dst_addr_i,
    input  logic [LenW-1:0] len_words_i,
    input  logic [31:0]     exp_sum_i,
    output tl_h2d_t         tl_o,
    input  tl_d2h_t         tl_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic            err_o,
    output logic [31:0]     sum_o,
    output logic            fetch_en_o
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_RSP,
        ST_WR_REQ,
        ST_WR_RSP,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [31:0]     r_src;
    logic [31:0]     r_dst;
    logic [LenW-1:0] r_rem;
    logic [31:0]     r_exp;
    logic [31:0]     r_sum;
    logic [31:0]     r_data;
    logic            w_start_ok;
    logic            w_misaligned;
    logic            w_rd_ok;
    logic            w_wr_ok;
    tl_h2d_t         w_tl_a;
    logic            w_unused_d;

    assign w_start_ok   = start_i && (r_state inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign w_misaligned = SrcAlignChk && ((|src_addr_i[1:0]) || (|dst_addr_i[1:0]));
    assign w_rd_ok      = (r_state == ST_RD_RSP) && tl_i.d_valid && !tl_i.d_error;
    assign w_wr_ok      = (r_state == ST_WR_RSP) && tl_i.d_valid && !tl_i.d_error;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    if (w_misaligned)                 w_state_nxt = ST_ERROR;
                    else if (len_words_i == '0)       w_state_nxt = ST_CHECK;
                    else                              w_state_nxt = ST_RD_REQ;
                end
            end
            ST_RD_REQ: if (tl_i.a_ready) w_state_nxt = ST_RD_RSP;
            ST_RD_RSP: begin
                if (tl_i.d_valid) w_state_nxt = tl_i.d_error ? ST_ERROR : ST_WR_REQ;
            end
            ST_WR_REQ: if (tl_i.a_ready) w_state_nxt = ST_WR_RSP;
            ST_WR_RSP: begin
                if (tl_i.d_valid) begin
                    if (tl_i.d_error)               w_state_nxt = ST_ERROR;
                    else if (r_rem == LenW'(1))     w_state_nxt = ST_CHECK;
                    else                            w_state_nxt = ST_RD_REQ;
                end
            end
            ST_CHECK: w_state_nxt = (r_sum == r_exp) ? ST_DONE : ST_ERROR;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_rem  <= '0;
            r_exp  <= '0;
            r_sum  <= '0;
            r_data <= '0;
        end else if (w_start_ok) begin
            r_src <= src_addr_i;
            r_dst <= dst_addr_i;
            r_rem <= len_words_i;
            r_exp <= exp_sum_i;
            r_sum <= '0;
        end else if (w_rd_ok) begin
            r_data <= tl_i.d_data;
            r_sum  <= r_sum + tl_i.d_data;
        end else if (w_wr_ok) begin
            // Address wrap past 0xFFFF_FFFC is intentionally silent.
            r_src <= r_src + 32'd4;
            r_dst <= r_dst + 32'd4;
            r_rem <= r_rem - LenW'(1);
        end
    end

    always_comb begin
        w_tl_a           = '0;
        w_tl_a.a_opcode  = Get;
        w_tl_a.a_size    = 2'd2;
        w_tl_a.a_mask    = 4'hF;
        w_tl_a.a_address = r_src;
        w_tl_a.d_ready   = 1'b1;
        case (r_state)
            ST_RD_REQ: w_tl_a.a_valid = 1'b1;
            ST_WR_REQ: begin
                w_tl_a.a_valid   = 1'b1;
                w_tl_a.a_opcode  = PutFullData;
                w_tl_a.a_address = r_dst;
                w_tl_a.a_data    = r_data;
            end
            default: ;
        endcase
    end

    tlul_cmd_intg_gen u_cmd_intg (
        .i_tl (w_tl_a),
        .o_tl (tl_o)
    );

    assign w_unused_d = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                          tl_i.d_source, tl_i.d_sink, tl_i.d_user};

    assign busy_o     = r_state inside {ST_RD_REQ, ST_RD_RSP, ST_WR_REQ, ST_WR_RSP, ST_CHECK};
    assign done_o     = (r_state == ST_DONE) || (r_state == ST_ERROR);
    assign pass_o     = (r_state == ST_DONE);
    assign err_o      = (r_state == ST_ERROR);
    assign fetch_en_o = pass_o;
    assign sum_o      = r_sum;
endmodule

// File: doc/boot_img_loader.md
Name: boot_img_loader

Overview:
- TL-UL host that copies a boot image word by word from the ROM region into exec SRAM, before the core fetches from it.
- Accumulates a 32-bit additive checksum of every word copied and compares it against an expected value.
- Raises fetch_en_o only on a clean, matching copy; sits beside the core as an extra host port on the crossbar, gating core fetch enable.
- Exactly one outstanding TL-UL transaction at any time.

Parameters:
- LenW, 16, width of the word-count input; maximum copy length is 2^LenW-1 words.
- SrcAlignChk, 1, when 1 a misaligned src/dst address (bits [1:0] != 0) at start goes to ERROR.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- start_i  input  1  single-cycle start pulse; sampled only in IDLE, DONE or ERROR.
- src_addr_i  input  32  source byte address, latched on start.
- dst_addr_i  input  32  destination byte address, latched on start.
- len_words_i  input  LenW  number of 32-bit words to copy, latched on start.
- exp_sum_i  input  32  expected checksum, latched on start.
- tl_o  output  tlul_pkg::tl_h2d_t  TL-UL A channel plus d_ready.
- tl_i  input  tlul_pkg::tl_d2h_t  TL-UL D channel plus a_ready.
- busy_o  output  1  high from the accepted start until DONE or ERROR.
- done_o  output  1  sticky; high in DONE and in ERROR.
- pass_o  output  1  sticky; 1 only in DONE when the checksum matched.
- err_o  output  1  sticky; 1 on d_error, misalignment or checksum mismatch.
- sum_o  output  32  running checksum.
- fetch_en_o  output  1  equals pass_o; the core fetch gate.

Behaviour:
- Reset values:
  - All outputs 0, state IDLE.
  - tl_o.a_valid=0, tl_o.d_ready=1.
  - Reset mid-transfer aborts immediately; no handshake completes after rst_ni falls.
- States: IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP, CHECK, DONE, ERROR.
- Start (accepted in IDLE/DONE/ERROR):
  - Latch src, dst, len, exp.
  - Clear sum, done, pass, err; set busy.
  - Misaligned address with SrcAlignChk=1 -> ERROR.
  - Otherwise len==0 -> CHECK; else -> RD_REQ.
  - start_i in any other state is ignored.
- RD_REQ:
  - a_valid=1, a_opcode=Get, a_address=src, a_size=2, a_mask=4'hF, a_source=0.
  - a_user integrity generated by tlul_cmd_intg_gen.
  - All A fields held stable until a_valid&&a_ready, then -> RD_RSP.
- RD_RSP: wait for d_valid (d_ready=1 in all states).
  - d_error=1 -> ERROR.
  - Else capture d_data into the data register, sum <= sum + d_data (mod 2^32), -> WR_REQ.
- WR_REQ:
  - a_opcode=PutFullData, a_address=dst, a_data=captured word, a_mask=4'hF.
  - Hold stable until accepted -> WR_RSP.
- WR_RSP: on d_valid:
  - d_error -> ERROR.
  - Else src+=4, dst+=4 (32-bit wrap, no error), remaining-=1.
  - remaining==0 -> CHECK, else -> RD_REQ.
- CHECK (one cycle):
  - sum==exp -> DONE with pass=1.
  - Else -> ERROR with err=1.
- DONE / ERROR:
  - busy=0, done=1.
  - Stay until the next start.
- Latency per word with zero-wait devices (a_ready=1, d_valid the cycle after acceptance): 4 cycles; total = 4*len + 2 cycles from start to done_o.
- A D response arriving in a non-RSP state is ignored.

Test Plan:
1. len=4, ROM words 1,2,3,4, exp=10 -> 4 Gets then 4 Puts at dst..dst+12 in order; done=1, pass=1, fetch_en=1, sum=10; 18 cycles with zero-wait devices.
2. Same image, exp=11 -> all 4 words still written; sum=10, err=1, pass=0, fetch_en=0.
3. a_ready held low 5 cycles on the 2nd Get -> a_valid and all A fields stable throughout; final result identical to test 1.
4. d_error=1 on the 3rd write response -> ERROR; exactly 3 Puts issued, err=1, done=1, busy=0, fetch_en=0.
5. len=0, exp=0 -> no TL traffic; pass=1 two cycles after start. src=0x0000_0002 -> err=1, no TL traffic.
6. rst_ni asserted during WR_REQ of word 2 -> all outputs 0, a_valid=0 asynchronously; a new start after reset copies from scratch.
